switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_pkg.sv | 9 +
 rtl/debounce_bit.sv | 65 ++++++
 rtl/switch_debouncer.sv | 33 +++
 tb/tb_switch_debouncer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared defaults for the switch debouncer: bus width, debounce window and
// the counter width derived from it.
package switch_pkg;

  localparam int DEFAULT_WIDTH           = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEBOUNCE_CNT_W          = $clog2(DEFAULT_DEBOUNCE_CYCLES);

endpackage : switch_pkg

// File: rtl/debounce_bit.sv
// One debounced switch bit: two-flop synchronizer, persistence counter,
// accepted-level register and a one-cycle change pulse.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw_i,
  output logic sw_debounced_o,
  output logic sw_changed_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             changed_q, changed_d;

  // s1 -> s2 is a straight wire so the second flop gets a full cycle to settle.
  always_comb begin
    s1_d = sw_raw_i;
    s2_d = s1_q;
  end

  // Any cycle that agrees with the accepted level restarts the window; the
  // counter saturates at CNT_MAX only for the single accepting edge.
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    changed_d = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d   = s2_q;
        changed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      changed_q <= changed_d;
    end
  end

  assign sw_debounced_o = level_q;
  assign sw_changed_o   = changed_q;

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// Debounces a bus of board switches; each bit runs its own independent
// debounce_bit and any_change flags a pulse on any of them.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          ($clog2(DEBOUNCE_CYCLES))
    ) u_bit (
      .clk           (clk),
      .reset         (reset),
      .sw_raw_i      (sw_raw[i]),
      .sw_debounced_o(sw_debounced[i]),
      .sw_changed_o  (sw_changed[i])
    );
  end

  // Driven only by sw_changed flops, so it is glitch-free.
  assign any_change = |sw_changed;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (WIDTH=10, DEBOUNCE_CYCLES=8): a
// window-based reference model checked every cycle plus literal expectations.
module tb_switch_debouncer;

  localparam int W = 10;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_debounced;
  logic [W-1:0] sw_changed;
  logic         any_change;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .sw_debounced(sw_debounced),
    .sw_changed  (sw_changed),
    .any_change  (any_change)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A bit is accepted when the last D synchronized samples all disagree with
  // its accepted level; the raw input reaches the synchronized view 2 edges late.
  logic [W-1:0] m_p1, m_p2, m_deb, m_chg;
  logic [W-1:0] s2_hist[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p1 = '0; m_p2 = '0; m_deb = '0; m_chg = '0;
      s2_hist.delete();
    end else begin
      s2_hist.push_front(m_p2);
      if (s2_hist.size() > D) void'(s2_hist.pop_back());
      m_chg = '0;
      for (int b = 0; b < W; b++) begin
        bit all_diff;
        all_diff = (s2_hist.size() == D);
        for (int k = 0; k < s2_hist.size(); k++)
          if (s2_hist[k][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_deb[b] = ~m_deb[b];
          m_chg[b] = 1'b1;
        end
      end
      m_p2 = m_p1;
      m_p1 = sw_raw;
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  logic [W-1:0] exp_q[$];
  int           chg9_seen = 0;

  always @(negedge clk) begin
    exp_q.push_back(m_deb);
    checks++;
    if (sw_debounced !== exp_q[0] || sw_changed !== m_chg || any_change !== (|m_chg)) begin
      errors++;
      $display("FAIL model_cmp t=%0t deb=%h/%h chg=%h/%h any=%b/%b (actual/required)",
               $time, sw_debounced, exp_q[0], sw_changed, m_chg, any_change, |m_chg);
    end
    void'(exp_q.pop_front());
    if (sw_changed[9]) chg9_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(negedge clk);
    step(2);
    chk("reset_deb", sw_debounced, 10'h000);
    chk("reset_chg", sw_changed, 10'h000);
    chk("reset_any", {9'd0, any_change}, 10'h000);
    reset = 1'b0;

    // Clean rise on bit 0
    sw_raw = 10'h001;
    step(9);
    chk("rise_before", sw_debounced, 10'h000);
    step(1);
    chk("rise_deb", sw_debounced, 10'h001);
    chk("rise_chg", sw_changed, 10'h001);
    chk("rise_any", {9'd0, any_change}, 10'h001);
    step(1);
    chk("rise_chg_off", sw_changed, 10'h000);
    chk("rise_any_off", {9'd0, any_change}, 10'h000);
    sw_raw = 10'h000;
    step(12);
    chk("rise_clear", sw_debounced, 10'h000);

    // Bounce on bit 3: 3 high / 3 low for 30 cycles, then held high
    for (int c = 0; c < 30; c++) begin
      sw_raw = ((c / 3) % 2 == 0) ? 10'h008 : 10'h000;
      step(1);
      chk("bounce_hold", sw_debounced, 10'h000);
    end
    sw_raw = 10'h008;
    step(9);
    chk("bounce_before", sw_debounced, 10'h000);
    step(1);
    chk("bounce_deb", sw_debounced, 10'h008);
    chk("bounce_chg", sw_changed, 10'h008);
    sw_raw = 10'h000;
    step(12);

    // Short glitch on bit 9: 7 cycles high
    chg9_seen = 0;
    sw_raw = 10'h200;
    step(7);
    sw_raw = 10'h000;
    step(15);
    chk("glitch_deb", sw_debounced, 10'h000);
    chk("glitch_chg_seen", 10'(chg9_seen), 10'h000);

    // Bit 0 toggling every cycle never settles
    for (int c = 0; c < 24; c++) begin
      sw_raw = 10'(c % 2);
      step(1);
    end
    sw_raw = 10'h000;
    step(4);
    chk("toggle_deb", sw_debounced, 10'h000);

    // Simultaneous change on all bits
    sw_raw = 10'h3FF;
    step(9);
    chk("all_before", sw_debounced, 10'h000);
    step(1);
    chk("all_deb", sw_debounced, 10'h3FF);
    chk("all_chg", sw_changed, 10'h3FF);
    step(1);
    chk("all_chg_off", sw_changed, 10'h000);

    // Falling edge on bit 0 only
    sw_raw = 10'h3FE;
    step(10);
    chk("fall_deb", sw_debounced, 10'h3FE);
    chk("fall_chg", sw_changed, 10'h001);
    step(1);
    chk("fall_chg_off", sw_changed, 10'h000);

    // Reset mid-count on bit 5
    sw_raw = 10'h000;
    step(12);
    sw_raw = 10'h020;
    step(7);
    reset = 1'b1;
    #1;
    chk("rst_async_deb", sw_debounced, 10'h000);
    step(2);
    chk("rst_hold_deb", sw_debounced, 10'h000);
    chk("rst_hold_chg", sw_changed, 10'h000);
    reset = 1'b0;
    step(9);
    chk("rst_before", sw_debounced, 10'h000);
    step(1);
    chk("rst_deb", sw_debounced, 10'h020);
    chk("rst_chg", sw_changed, 10'h020);
    step(1);
    chk("rst_chg_off", sw_changed, 10'h000);

    // Random tail checked by the model only
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 9) == 0) sw_raw = W'($urandom_range(0, 1023));
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_switch_debouncer
